miu_cache: RTL and testbench
============================

Name: miu_cache

Overview:
- Cache-side responder for the MIU request/response channel: accepts one byte load/store from the MIU, returns exactly one response, then accepts the next request.
- Direct-mapped, write-through, no-write-allocate byte cache with multi-byte lines.
- Read misses refill a full line from a backing byte memory over a simple valid/ready request channel with a separate response channel.
- Sits between the MIU and the memory model; one transaction in flight on each side.

Parameters:
ADDR_W, 16, byte address width (matches system ADDR_W)
LINE_BYTES, 4, bytes per line, power of 2, >=2
NUM_LINES, 16, number of lines, power of 2

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
cache_req_valid  input  1  MIU request valid
cache_req_ready  output  1  cache can accept a request
cache_req_we  input  1  1=store, 0=load
cache_req_addr  input  ADDR_W  byte address
cache_req_write  input  8  store data
cache_resp_valid  output  1  one-cycle response pulse
cache_resp_data  output  8  load data / echoed store data
mem_req_valid  output  1  backing-memory request valid
mem_req_ready  input  1  memory accepts request
mem_req_we  output  1  1=write, 0=read
mem_req_addr  output  ADDR_W  memory byte address
mem_req_wdata  output  8  memory write data
mem_resp_valid  input  1  memory read data / write ack
mem_resp_data  input  8  memory read data

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - state IDLE; all line valid bits 0.
  - cache_resp_valid=0, cache_resp_data=0.
  - mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0.
  - Tag/data arrays need no reset.
- Address split: offset = addr[log2(LINE_BYTES)-1:0]; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- cache_req_ready = (state==IDLE). It is a combinational decode of state only.
- Request acceptance:
  - A request is accepted on a clock edge where valid && ready.
  - On acceptance, latch we, addr and wdata; go to LOOKUP.
  - cache_req_valid while not IDLE is ignored; nothing is latched.
- States:
  - IDLE: wait for handshake.
  - LOOKUP, 1 cycle: hit = valid[index] && tag match.
    - Read hit: latch the byte to cache_resp_data; go to RESPOND.
    - Read miss: clear valid[index], beat=0; go to REFILL_REQ.
    - Write hit: update the byte in the data array; go to WRITE_REQ.
    - Write miss: array unchanged; go to WRITE_REQ.
  - REFILL_REQ:
    - mem_req_valid=1, we=0, addr={tag,index,beat}.
    - Valid, addr and we are held stable until mem_req_ready; on the handshake edge go to REFILL_WAIT with mem_req_valid=0.
  - REFILL_WAIT:
    - On mem_resp_valid, write mem_resp_data to data[index][beat].
    - If beat==LINE_BYTES-1: set valid[index], write the tag, load cache_resp_data with the requested offset byte (the stored byte, or mem_resp_data when offset==beat), go to RESPOND.
    - Otherwise beat++ and go to REFILL_REQ.
    - Beats are strictly sequential from offset 0; one memory request outstanding at a time.
  - WRITE_REQ: mem_req_valid=1, we=1, addr=latched addr, wdata=latched data; held until handshake, then go to WRITE_WAIT.
  - WRITE_WAIT: on mem_resp_valid (ack, data ignored), cache_resp_data = stored byte; go to RESPOND.
  - RESPOND: cache_resp_valid=1 for exactly this one cycle; go to IDLE.
- cache_resp_data holds its value between responses.
- Latency:
  - Read hit: accept edge at cycle N, cache_resp_valid high in cycle N+2; the next request can be accepted at the end of cycle N+3.
  - Miss/write latency adds memory handshake and response cycles.
- mem_resp_valid outside REFILL_WAIT/WRITE_WAIT is ignored.
- mem_resp_valid in the same cycle as the request handshake is not possible: the response is counted only in the WAIT state.
- Reset mid-operation:
  - Immediate return to IDLE; all valid bits cleared; outputs at reset values.
  - Any partial refill is discarded; the memory side is reset together.

Test Plan:
- Cold read miss, addr 0x0123 (index 8, tag 4), mem_req_ready low 3 cycles on the first beat:
  - mem_req_addr stays 0x0120 while stalled.
  - Then reads go to 0x0120..0x0123; memory returns 0xA0..0xA3.
  - Single cache_resp_valid pulse with data 0xA3.
- Then read 0x0121: no mem_req_valid; cache_resp_valid exactly 2 cycles after the accept edge, data 0xA1; cache_req_ready low from accept until after RESPOND.
- Write 0x0122 data 0x5C (hit): one memory write addr 0x0122 wdata 0x5C; after ack, response pulse. Then read 0x0122 hits with 0x5C.
- Conflict on index 8, read 0x0163: miss, refill 0x0160..0x0163 with 0xB0..0xB3, response 0xB3. Then read 0x0121 misses and refills again.
- Write miss 0x0200 data 0x77: exactly one memory write, no refill reads. Then read 0x0200 misses.
- Reset asserted in REFILL_WAIT (beat 2):
  - mem_req_valid and cache_resp_valid are 0 immediately; cache_req_ready=1 after release.
  - Read 0x0121 then misses; a stray mem_resp_valid while IDLE has no effect.

Source files
------------

// File: rtl/miu_cache_if.sv
// MIU request/response channel and backing-memory channel of the byte cache.
interface miu_cache_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              cache_req_valid;
    logic              cache_req_ready;
    logic              cache_req_we;
    logic [ADDR_W-1:0] cache_req_addr;
    logic [7:0]        cache_req_write;
    logic              cache_resp_valid;
    logic [7:0]        cache_resp_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [7:0]        mem_req_wdata;
    logic              mem_resp_valid;
    logic [7:0]        mem_resp_data;

    modport slave (
        input  cache_req_valid, cache_req_we, cache_req_addr, cache_req_write,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        output cache_req_ready, cache_resp_valid, cache_resp_data,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

    modport master (
        output cache_req_valid, cache_req_we, cache_req_addr, cache_req_write,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        input  cache_req_ready, cache_resp_valid, cache_resp_data,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );
endinterface

// File: rtl/miu_cache.sv
// Direct-mapped, write-through, no-write-allocate byte cache answering one MIU
// request at a time; read misses refill a whole line byte by byte from memory.
module miu_cache #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned LINE_BYTES = 4,
    parameter int unsigned NUM_LINES  = 16
) (
    input  logic         clk,
    input  logic         reset,
    miu_cache_if.slave   bus
);
    localparam int unsigned OFF_W = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, WRITE_REQ, WRITE_WAIT, RESPOND
    } state_e;

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [OFF_W-1:0]     beat_q, beat_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [7:0]           resp_data_q, resp_data_d;
    logic                 mreq_valid_q, mreq_valid_d;
    logic                 mreq_we_q, mreq_we_d;
    logic [ADDR_W-1:0]    mreq_addr_q, mreq_addr_d;
    logic [7:0]           mreq_wdata_q, mreq_wdata_d;

    logic [7:0]           data_mem [NUM_LINES][LINE_BYTES];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic                 data_we, tag_we;
    logic [OFF_W-1:0]     data_off;
    logic [7:0]           data_wr;

    logic [OFF_W-1:0]     req_off;
    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic                 hit;

    assign req_off = addr_q[OFF_W-1:0];
    assign req_idx = addr_q[OFF_W +: IDX_W];
    assign req_tag = addr_q[ADDR_W-1 -: TAG_W];
    assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        beat_d       = beat_q;
        valid_d      = valid_q;
        resp_data_d  = resp_data_q;
        mreq_addr_d  = mreq_addr_q;
        mreq_wdata_d = mreq_wdata_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        data_off     = beat_q;
        data_wr      = bus.mem_resp_data;

        case (state_q)
            IDLE: begin
                if (bus.cache_req_valid) begin
                    we_d    = bus.cache_req_we;
                    addr_d  = bus.cache_req_addr;
                    wdata_d = bus.cache_req_write;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!we_q) begin
                    if (hit) begin
                        resp_data_d = data_mem[req_idx][req_off];
                        state_d     = RESPOND;
                    end else begin
                        valid_d[req_idx] = 1'b0;
                        beat_d           = '0;
                        state_d          = REFILL_REQ;
                    end
                end else begin
                    // write-through: update a resident line, never allocate
                    if (hit) begin
                        data_we  = 1'b1;
                        data_off = req_off;
                        data_wr  = wdata_q;
                    end
                    state_d = WRITE_REQ;
                end
            end
            REFILL_REQ: begin
                if (bus.mem_req_ready) state_d = REFILL_WAIT;
            end
            REFILL_WAIT: begin
                if (bus.mem_resp_valid) begin
                    data_we = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        valid_d[req_idx] = 1'b1;
                        tag_we           = 1'b1;
                        // the requested byte may be the one arriving right now
                        resp_data_d = (req_off == beat_q) ? bus.mem_resp_data
                                                          : data_mem[req_idx][req_off];
                        state_d     = RESPOND;
                    end else begin
                        beat_d  = beat_q + OFF_W'(1);
                        state_d = REFILL_REQ;
                    end
                end
            end
            WRITE_REQ: begin
                if (bus.mem_req_ready) state_d = WRITE_WAIT;
            end
            WRITE_WAIT: begin
                if (bus.mem_resp_valid) begin
                    resp_data_d = wdata_q;
                    state_d     = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // registered outputs follow the state being entered
        resp_valid_d = (state_d == RESPOND);
        mreq_valid_d = (state_d == REFILL_REQ) || (state_d == WRITE_REQ);
        mreq_we_d    = (state_d == WRITE_REQ);
        if (state_d == REFILL_REQ) mreq_addr_d = {req_tag, req_idx, beat_d};
        if (state_d == WRITE_REQ) begin
            mreq_addr_d  = addr_q;
            mreq_wdata_d = wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            beat_q       <= '0;
            valid_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mreq_valid_q <= 1'b0;
            mreq_we_q    <= 1'b0;
            mreq_addr_q  <= '0;
            mreq_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            beat_q       <= beat_d;
            valid_q      <= valid_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mreq_valid_q <= mreq_valid_d;
            mreq_we_q    <= mreq_we_d;
            mreq_addr_q  <= mreq_addr_d;
            mreq_wdata_q <= mreq_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_mem[req_idx][data_off] <= data_wr;
        if (tag_we)  tag_mem[req_idx] <= req_tag;
    end

    assign bus.cache_req_ready  = (state_q == IDLE);
    assign bus.cache_resp_valid = resp_valid_q;
    assign bus.cache_resp_data  = resp_data_q;
    assign bus.mem_req_valid    = mreq_valid_q;
    assign bus.mem_req_we       = mreq_we_q;
    assign bus.mem_req_addr     = mreq_addr_q;
    assign bus.mem_req_wdata    = mreq_wdata_q;
endmodule

// File: tb/tb_miu_cache.sv
// Directed bench for miu_cache with a one-request-at-a-time backing memory model.
module tb_miu_cache;
    localparam int unsigned ADDR_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    miu_cache_if #(.ADDR_W(ADDR_W)) bus ();
    miu_cache #(.ADDR_W(ADDR_W), .LINE_BYTES(4), .NUM_LINES(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // memory model state; only the model process writes these
    logic [7:0]  wmem [logic [15:0]];
    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];
    logic [7:0]  wd_log[$];
    logic [15:0] stall_log[$];
    int          stall_done = 0;
    int          stray_seen = 0;
    bit          resp_pending = 1'b0;
    logic [7:0]  resp_byte = 8'h00;

    // knobs written only by the test sequence
    int stall_budget = 0;
    int stray_req = 0;

    // per-transaction observations
    logic [7:0] r_data;
    int         r_lat, r_pulses, rd_base, wr_base;
    bit         r_rdy_ok, r_rdy_after;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        if (a[15:2] == 14'h0048) return 8'hA0 + 8'(a[1:0]);
        if (a[15:2] == 14'h0058) return 8'hB0 + 8'(a[1:0]);
        return a[7:0] ^ 8'h5A;
    endfunction

    // memory: accepts a request one negedge ahead of the edge, answers one cycle later
    always @(negedge clk) begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        if (reset) begin
            resp_pending = 1'b0;
        end else if (stray_req != stray_seen) begin
            stray_seen         = stray_req;
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 8'hEE;
        end else if (resp_pending) begin
            resp_pending       = 1'b0;
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = resp_byte;
        end else if (bus.mem_req_valid) begin
            if (stall_done < stall_budget) begin
                stall_done++;
                stall_log.push_back(bus.mem_req_addr);
            end else begin
                bus.mem_req_ready = 1'b1;
                resp_pending      = 1'b1;
                if (bus.mem_req_we) begin
                    wmem[bus.mem_req_addr] = bus.mem_req_wdata;
                    wr_log.push_back(bus.mem_req_addr);
                    wd_log.push_back(bus.mem_req_wdata);
                    resp_byte = 8'h00;
                end else begin
                    rd_log.push_back(bus.mem_req_addr);
                    resp_byte = wmem.exists(bus.mem_req_addr) ? wmem[bus.mem_req_addr]
                                                              : init_byte(bus.mem_req_addr);
                end
            end
        end
    end

    // one MIU transaction; valid stays up (with junk payload) one cycle past accept
    task automatic do_req(input bit we, input logic [15:0] a, input logic [7:0] wd);
        r_lat = -1; r_pulses = 0; r_rdy_after = 1'b0; r_data = 8'hxx;
        rd_base = rd_log.size(); wr_base = wr_log.size();
        @(negedge clk);
        r_rdy_ok = bus.cache_req_ready;
        bus.cache_req_valid = 1'b1; bus.cache_req_we = we;
        bus.cache_req_addr = a; bus.cache_req_write = wd;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.cache_req_addr = 16'hFFFF; bus.cache_req_write = 8'hFF; bus.cache_req_we = ~we;
            end
            if (cyc == 2) bus.cache_req_valid = 1'b0;
            if (bus.cache_resp_valid) begin
                r_pulses++;
                if (r_lat < 0) begin r_lat = cyc; r_data = bus.cache_resp_data; end
            end
            if (r_lat < 0 && bus.cache_req_ready) r_rdy_ok = 1'b0;
            if (r_lat >= 0 && cyc == r_lat + 1) r_rdy_after = bus.cache_req_ready;
            if (r_lat >= 0 && cyc >= r_lat + 3) break;
        end
        bus.cache_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cache_req_valid = 1'b0; bus.cache_req_we = 1'b0;
        bus.cache_req_addr = '0; bus.cache_req_write = '0;
        repeat (3) @(negedge clk);
        tests++; if (bus.cache_resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", bus.cache_resp_valid); end
        tests++; if (bus.cache_resp_data !== 8'h00) begin fails++; $display("FAIL reset_resp_data got %h want 00", bus.cache_resp_data); end
        tests++; if (bus.mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid got %b want 0", bus.mem_req_valid); end
        tests++; if (bus.mem_req_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b want 0", bus.mem_req_we); end
        tests++; if (bus.mem_req_addr !== 16'h0000) begin fails++; $display("FAIL reset_mem_addr got %h want 0000", bus.mem_req_addr); end
        tests++; if (bus.mem_req_wdata !== 8'h00) begin fails++; $display("FAIL reset_mem_wdata got %h want 00", bus.mem_req_wdata); end
        reset = 1'b0;
        @(negedge clk);
        tests++; if (bus.cache_req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.cache_req_ready); end
    endtask

    task automatic test_cold_miss();
        int sbase;
        sbase = stall_log.size();
        stall_budget = stall_done + 3;
        do_req(1'b0, 16'h0123, 8'h00);
        tests++; if (stall_log.size() - sbase !== 3) begin fails++; $display("FAIL cold_stall_cycles got %0d want 3", stall_log.size() - sbase); end
        for (int k = 0; k < 3; k++) begin
            tests++; if (stall_log[sbase+k] !== 16'h0120) begin fails++; $display("FAIL cold_stall_addr[%0d] got %h want 0120", k, stall_log[sbase+k]); end
        end
        tests++; if (rd_log.size() - rd_base !== 4) begin fails++; $display("FAIL cold_reads got %0d want 4", rd_log.size() - rd_base); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (rd_log[rd_base+k] !== 16'h0120 + 16'(k)) begin fails++; $display("FAIL cold_read_addr[%0d] got %h want %h", k, rd_log[rd_base+k], 16'h0120 + 16'(k)); end
        end
        tests++; if (wr_log.size() - wr_base !== 0) begin fails++; $display("FAIL cold_writes got %0d want 0", wr_log.size() - wr_base); end
        tests++; if (r_pulses !== 1) begin fails++; $display("FAIL cold_pulses got %0d want 1", r_pulses); end
        tests++; if (r_data !== 8'hA3) begin fails++; $display("FAIL cold_data got %h want a3", r_data); end
    endtask

    task automatic test_read_hit();
        do_req(1'b0, 16'h0121, 8'h00);
        tests++; if (rd_log.size() - rd_base !== 0) begin fails++; $display("FAIL hit_mem_reads got %0d want 0", rd_log.size() - rd_base); end
        tests++; if (r_lat !== 2) begin fails++; $display("FAIL hit_latency got %0d want 2", r_lat); end
        tests++; if (r_data !== 8'hA1) begin fails++; $display("FAIL hit_data got %h want a1", r_data); end
        tests++; if (r_pulses !== 1) begin fails++; $display("FAIL hit_pulses got %0d want 1", r_pulses); end
        tests++; if (r_rdy_ok !== 1'b1) begin fails++; $display("FAIL hit_ready_low got %b want 1", r_rdy_ok); end
        tests++; if (r_rdy_after !== 1'b1) begin fails++; $display("FAIL hit_ready_after got %b want 1", r_rdy_after); end
    endtask

    task automatic test_write_hit();
        do_req(1'b1, 16'h0122, 8'h5C);
        tests++; if (wr_log.size() - wr_base !== 1) begin fails++; $display("FAIL wh_writes got %0d want 1", wr_log.size() - wr_base); end
        tests++; if (wr_log[wr_base] !== 16'h0122) begin fails++; $display("FAIL wh_addr got %h want 0122", wr_log[wr_base]); end
        tests++; if (wd_log[wr_base] !== 8'h5C) begin fails++; $display("FAIL wh_wdata got %h want 5c", wd_log[wr_base]); end
        tests++; if (rd_log.size() - rd_base !== 0) begin fails++; $display("FAIL wh_reads got %0d want 0", rd_log.size() - rd_base); end
        tests++; if (r_pulses !== 1) begin fails++; $display("FAIL wh_pulses got %0d want 1", r_pulses); end
        tests++; if (r_data !== 8'h5C) begin fails++; $display("FAIL wh_echo got %h want 5c", r_data); end
        do_req(1'b0, 16'h0122, 8'h00);
        tests++; if (rd_log.size() - rd_base !== 0) begin fails++; $display("FAIL wh_readback_reads got %0d want 0", rd_log.size() - rd_base); end
        tests++; if (r_lat !== 2) begin fails++; $display("FAIL wh_readback_latency got %0d want 2", r_lat); end
        tests++; if (r_data !== 8'h5C) begin fails++; $display("FAIL wh_readback_data got %h want 5c", r_data); end
    endtask

    task automatic test_conflict();
        do_req(1'b0, 16'h0163, 8'h00);
        tests++; if (rd_log.size() - rd_base !== 4) begin fails++; $display("FAIL conf_reads got %0d want 4", rd_log.size() - rd_base); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (rd_log[rd_base+k] !== 16'h0160 + 16'(k)) begin fails++; $display("FAIL conf_read_addr[%0d] got %h want %h", k, rd_log[rd_base+k], 16'h0160 + 16'(k)); end
        end
        tests++; if (r_data !== 8'hB3) begin fails++; $display("FAIL conf_data got %h want b3", r_data); end
        tests++; if (r_pulses !== 1) begin fails++; $display("FAIL conf_pulses got %0d want 1", r_pulses); end
        do_req(1'b0, 16'h0121, 8'h00);
        tests++; if (rd_log.size() - rd_base !== 4) begin fails++; $display("FAIL conf_back_reads got %0d want 4", rd_log.size() - rd_base); end
        tests++; if (rd_log[rd_base] !== 16'h0120) begin fails++; $display("FAIL conf_back_first got %h want 0120", rd_log[rd_base]); end
        tests++; if (r_data !== 8'hA1) begin fails++; $display("FAIL conf_back_data got %h want a1", r_data); end
    endtask

    task automatic test_write_miss();
        do_req(1'b1, 16'h0200, 8'h77);
        tests++; if (wr_log.size() - wr_base !== 1) begin fails++; $display("FAIL wm_writes got %0d want 1", wr_log.size() - wr_base); end
        tests++; if (wr_log[wr_base] !== 16'h0200) begin fails++; $display("FAIL wm_addr got %h want 0200", wr_log[wr_base]); end
        tests++; if (wd_log[wr_base] !== 8'h77) begin fails++; $display("FAIL wm_wdata got %h want 77", wd_log[wr_base]); end
        tests++; if (rd_log.size() - rd_base !== 0) begin fails++; $display("FAIL wm_reads got %0d want 0", rd_log.size() - rd_base); end
        tests++; if (r_data !== 8'h77) begin fails++; $display("FAIL wm_echo got %h want 77", r_data); end
        do_req(1'b0, 16'h0200, 8'h00);
        tests++; if (rd_log.size() - rd_base !== 4) begin fails++; $display("FAIL wm_readback_reads got %0d want 4", rd_log.size() - rd_base); end
        tests++; if (r_data !== 8'h77) begin fails++; $display("FAIL wm_readback_data got %h want 77", r_data); end
    endtask

    task automatic test_reset_mid();
        int  base;
        bit  seen;
        bit  bad_resp, bad_req, bad_rdy;
        base = rd_log.size();
        seen = 1'b0;
        @(negedge clk);
        bus.cache_req_valid = 1'b1; bus.cache_req_we = 1'b0;
        bus.cache_req_addr = 16'h0163; bus.cache_req_write = 8'h00;
        @(negedge clk);
        bus.cache_req_valid = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (rd_log.size() == base + 3 && bus.mem_req_valid === 1'b0) seen = 1'b1;
        end
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL rmid_reach_beat2 got %b want 1", seen); end
        #1 reset = 1'b1;
        #1;
        tests++; if (bus.mem_req_valid !== 1'b0) begin fails++; $display("FAIL rmid_mem_valid got %b want 0", bus.mem_req_valid); end
        tests++; if (bus.cache_resp_valid !== 1'b0) begin fails++; $display("FAIL rmid_resp_valid got %b want 0", bus.cache_resp_valid); end
        tests++; if (bus.cache_resp_data !== 8'h00) begin fails++; $display("FAIL rmid_resp_data got %h want 00", bus.cache_resp_data); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (bus.cache_req_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got %b want 1", bus.cache_req_ready); end
        do_req(1'b0, 16'h0121, 8'h00);
        tests++; if (rd_log.size() - rd_base !== 4) begin fails++; $display("FAIL rmid_miss_reads got %0d want 4", rd_log.size() - rd_base); end
        tests++; if (r_data !== 8'hA1) begin fails++; $display("FAIL rmid_miss_data got %h want a1", r_data); end
        stray_req++;
        bad_resp = 1'b0; bad_req = 1'b0; bad_rdy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.cache_resp_valid !== 1'b0) bad_resp = 1'b1;
            if (bus.mem_req_valid !== 1'b0) bad_req = 1'b1;
            if (bus.cache_req_ready !== 1'b1) bad_rdy = 1'b1;
        end
        tests++; if (bad_resp !== 1'b0) begin fails++; $display("FAIL stray_resp got %b want 0", bad_resp); end
        tests++; if (bad_req !== 1'b0) begin fails++; $display("FAIL stray_mem_req got %b want 0", bad_req); end
        tests++; if (bad_rdy !== 1'b0) begin fails++; $display("FAIL stray_ready_drop got %b want 0", bad_rdy); end
        do_req(1'b0, 16'h0121, 8'h00);
        tests++; if (rd_log.size() - rd_base !== 0) begin fails++; $display("FAIL stray_hit_reads got %0d want 0", rd_log.size() - rd_base); end
        tests++; if (r_lat !== 2) begin fails++; $display("FAIL stray_hit_latency got %0d want 2", r_lat); end
        tests++; if (r_data !== 8'hA1) begin fails++; $display("FAIL stray_hit_data got %h want a1", r_data); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_read_hit();
        test_write_hit();
        test_conflict();
        test_write_miss();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
